// File: rtl/midi_spi_master.sv
// MIDI note-on/off message to SPI (mode 0) master. One nss frame per byte, MSB first.
// Optional running status: define MIDI_RUNNING_STATUS_EN to skip a repeated status byte.
module midi_spi_master #(
  parameter int CLK_DIV    = 4,  // sclk half-period in clk cycles, 2..255
  parameter int GAP_CYCLES = 8   // nss-high cycles after every byte, >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] msg_status,
  input  logic [7:0] msg_note,
  input  logic [7:0] msg_velocity,
  output logic       msg_reject,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_nss,
  input  logic       spi_miso,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, GAP, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  div_cnt;
  logic [15:0] gap_cnt;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_idx, first_idx;
  logic [7:0]  status_q, note_q, vel_q, sh, echo;
  logic [7:0]  prev_byte, next_byte;
  logic        echo_err, ready_en;
  logic        status_ok, offer, accept, div_done, gap_done, last_byte, run_hit;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;  // 0 means none; 0 is never a legal status
  assign run_hit = (last_status == msg_status);
`else
  assign run_hit = 1'b0;
`endif

  assign status_ok = (msg_status == 8'h90) || (msg_status == 8'h80);
  assign offer     = msg_valid & msg_ready;
  assign accept    = offer & status_ok;
  assign div_done  = (div_cnt == 8'd0);
  assign gap_done  = (gap_cnt == 16'd0);
  assign last_byte = (byte_idx == 2'd2);
  assign prev_byte = (byte_idx == 2'd2) ? note_q : status_q;
  assign next_byte = (byte_idx == 2'd0) ? note_q : vel_q;

  // ready_en keeps msg_ready low until the first edge after reset releases
  assign msg_ready = (state == IDLE) & ready_en;
  assign busy      = (state != IDLE);
  assign spi_nss   = !((state == SETUP) || (state == SHIFT_HI) || (state == SHIFT_LO));
  assign spi_sclk  = (state == SHIFT_HI);
  assign spi_mosi  = !spi_nss & sh[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = SETUP;
      SETUP:    if (div_done) state_nxt = SHIFT_HI;
      SHIFT_HI: if (div_done) state_nxt = SHIFT_LO;
      SHIFT_LO: if (div_done) state_nxt = (bit_cnt == 3'd7) ? GAP : SHIFT_HI;
      GAP:      if (gap_done) state_nxt = last_byte ? DONE : SETUP;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en   <= 1'b0;
      msg_reject <= 1'b0;
      div_cnt    <= 8'd0;
      gap_cnt    <= 16'd0;
      bit_cnt    <= 3'd0;
      byte_idx   <= 2'd0;
      first_idx  <= 2'd0;
      status_q   <= 8'd0;
      note_q     <= 8'd0;
      vel_q      <= 8'd0;
      sh         <= 8'd0;
      echo       <= 8'd0;
      echo_err   <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      last_status <= 8'd0;
`endif
    end else begin
      ready_en   <= 1'b1;
      msg_reject <= offer & !status_ok;
      // every phase change is a state change, so the divider reloads there
      if (state != state_nxt)  div_cnt <= 8'(CLK_DIV - 1);
      else if (!div_done)      div_cnt <= div_cnt - 8'd1;
      // miso is sampled on the edge that raises sclk
      if (state_nxt == SHIFT_HI && state != SHIFT_HI) echo <= {echo[6:0], spi_miso};
      case (state)
        IDLE: begin
          if (accept) begin
            status_q  <= msg_status;
            note_q    <= msg_note;
            vel_q     <= msg_velocity;
            byte_idx  <= run_hit ? 2'd1 : 2'd0;
            first_idx <= run_hit ? 2'd1 : 2'd0;
            sh        <= run_hit ? msg_note : msg_status;
            bit_cnt   <= 3'd0;
            echo_err  <= 1'b0;
          end
`ifdef MIDI_RUNNING_STATUS_EN
          if (accept)                  last_status <= msg_status;
          else if (offer && !status_ok) last_status <= 8'd0;
`endif
        end
        SHIFT_HI: if (div_done) sh <= {sh[6:0], 1'b0};
        SHIFT_LO: if (div_done) begin
          if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
          else begin
            gap_cnt <= 16'(GAP_CYCLES - 1);
            // echo of this byte should match the previous byte; informational only
            echo_err <= echo_err | ((byte_idx != first_idx) && (echo != prev_byte));
          end
        end
        GAP: begin
          if (!gap_done) gap_cnt <= gap_cnt - 16'd1;
          else if (!last_byte) begin
            byte_idx <= byte_idx + 2'd1;
            sh       <= next_byte;
            bit_cnt  <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_spi_master.sv
// Directed bench for midi_spi_master (CLK_DIV=4, GAP_CYCLES=8) with an SPI slave monitor.
module tb_midi_spi_master;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       msg_valid = 1'b0;
  logic       msg_ready;
  logic [7:0] msg_status = 8'h00, msg_note = 8'h00, msg_velocity = 8'h00;
  logic       msg_reject, spi_sclk, spi_mosi, spi_nss, busy;
  logic       spi_miso;

  int checks = 0;
  int failures = 0;
  logic [7:0] rx_q [$];
  int frames = 0;

  assign spi_miso = spi_mosi;

  midi_spi_master #(.CLK_DIV(4), .GAP_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_status(msg_status), .msg_note(msg_note), .msg_velocity(msg_velocity),
    .msg_reject(msg_reject), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_nss(spi_nss), .spi_miso(spi_miso), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI slave: samples mosi on sclk rise, one byte per nss frame
  initial begin
    logic p_sclk, p_mosi, p_nss;
    logic [7:0] sr;
    int nbits;
    p_sclk = 1'b0; p_mosi = 1'b0; p_nss = 1'b1; sr = 8'h00; nbits = 0;
    forever begin
      @(negedge clk);
      if (spi_nss === 1'b1) chk("idle_lines", {spi_sclk, spi_mosi}, 2'b00);
      if (spi_nss === 1'b0 && !p_sclk && spi_sclk === 1'b1) begin
        chk("mosi_stable", spi_mosi, p_mosi);
        sr = {sr[6:0], spi_mosi};
        nbits++;
      end
      if (!p_nss && spi_nss === 1'b1) begin
        if (nbits == 8) begin rx_q.push_back(sr); frames++; end
        nbits = 0;
      end
      p_sclk = spi_sclk; p_mosi = spi_mosi; p_nss = spi_nss;
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!msg_ready && n < 2000);
  endtask

  task automatic offer(input logic [7:0] s, input logic [7:0] nt, input logic [7:0] v);
    @(negedge clk);
    msg_status = s; msg_note = nt; msg_velocity = v; msg_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_rx(input string tag, input int nexp, input logic [47:0] exp);
    chk({tag, "_count"}, rx_q.size(), nexp);
    for (int i = 0; i < nexp && i < rx_q.size(); i++)
      chk({tag, "_byte"}, rx_q[i], exp[47 - 8*i -: 8]);
    rx_q.delete();
  endtask

  task automatic send(input string tag, input logic [7:0] s, input logic [7:0] nt,
                      input logic [7:0] v, input int lat);
    int n;
    offer(s, nt, v);
    chk({tag, "_accept"}, {busy, spi_nss}, 2'b10);
    msg_valid = 1'b0;
    wait_ready(n);
    chk({tag, "_latency"}, n, lat);
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {spi_nss, spi_sclk, spi_mosi, msg_ready, msg_reject, busy}, 6'b100000);
    @(negedge clk); reset = 1'b0;
    #1 chk("rst_ready_before_edge", msg_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst_ready_after_edge", msg_ready, 1'b1);

    // basic message
    send("msg1", 8'h90, 8'h3C, 8'h7F, 229);
    check_rx("msg1", 3, 48'h90_3C_7F_00_00_00);

    // reject
    offer(8'hB0, 8'h3C, 8'h7F);
    chk("rej_pulse", msg_reject, 1'b1);
    chk("rej_lines", {spi_nss, msg_ready, busy}, 3'b110);
    msg_valid = 1'b0;
    @(posedge clk); #1;
    chk("rej_pulse_end", msg_reject, 1'b0);
    repeat (10) @(posedge clk);
    #1 chk("rej_idle", {spi_nss, msg_ready, busy}, 3'b110);
    check_rx("rej", 0, 48'h0);

    // reset during bit 3 of the note byte
    offer(8'h90, 8'h3C, 8'h7F);
    msg_valid = 1'b0;
    repeat (104) @(posedge clk);
    #1 chk("mid_bit3", {spi_nss, spi_sclk, spi_mosi}, 3'b011);
    #2 reset = 1'b1;
    #1 chk("mid_rst", {spi_nss, spi_sclk, spi_mosi, msg_ready, busy}, 5'b10000);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_ready", msg_ready, 1'b1);
    check_rx("mid_partial", 1, 48'h90_00_00_00_00_00);
    send("after_rst", 8'h80, 8'h3C, 8'h00, 229);
    check_rx("after_rst", 3, 48'h80_3C_00_00_00_00);

    // back-to-back with msg_valid held; inputs change after acceptance
    frames = 0;
    offer(8'h90, 8'h3C, 8'h7F);
    chk("b2b_accept1", busy, 1'b1);
    msg_status = 8'h90; msg_note = 8'h40; msg_velocity = 8'h60;
    wait_ready(n);
    chk("b2b_latency1", n, 229);
    chk("b2b_gap", {spi_nss, busy}, 2'b10);
    @(posedge clk); #1;
    chk("b2b_accept2", busy, 1'b1);
    msg_valid = 1'b0;
    wait_ready(n);
`ifdef MIDI_RUNNING_STATUS_EN
    chk("b2b_latency2", n, 153);
    chk("b2b_frames", frames, 5);
    check_rx("b2b", 5, 48'h90_3C_7F_40_60_00);
`else
    chk("b2b_latency2", n, 229);
    chk("b2b_frames", frames, 6);
    check_rx("b2b", 6, 48'h90_3C_7F_90_40_60);
`endif

    // status change always sends the full message
    send("msg_off", 8'h80, 8'h40, 8'h00, 229);
    check_rx("msg_off", 3, 48'h80_40_00_00_00_00);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/midi_spi_master.md
MIDI_SPI_MASTER -- requirements
Module: midi_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles (legal range 2..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 8: NSS-high clk cycles inserted between bytes of one message.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port msg_valid, input, 1 bit: a message request is present.
REQ-006 SHALL have port msg_ready, output, 1 bit: the block accepts a message this cycle.
REQ-007 SHALL have port msg_status, input, 8 bits: MIDI status byte.
REQ-008 SHALL have port msg_note, input, 8 bits: MIDI note number.
REQ-009 SHALL have port msg_velocity, input, 8 bits: MIDI velocity.
REQ-010 SHALL have port msg_reject, output, 1 bit: one-cycle pulse when an offered message is refused.
REQ-011 SHALL have port spi_sclk, output, 1 bit: SPI clock.
REQ-012 SHALL have port spi_mosi, output, 1 bit: SPI data to the slave.
REQ-013 SHALL have port spi_nss, output, 1 bit: active-low slave select.
REQ-014 SHALL have port spi_miso, input, 1 bit: SPI data from the slave, sampled per REQ-026.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, SETUP, SHIFT_LO, SHIFT_HI, GAP and DONE.
REQ-017 SHALL drive msg_ready high only in IDLE; a transfer is accepted on a cycle with msg_valid & msg_ready.
REQ-018 SHALL accept only msg_status 8'h90 or 8'h80; any other value SHALL pulse msg_reject for one cycle, leave the block in IDLE and send nothing.
REQ-019 SHALL register status, note and velocity on acceptance; input changes after acceptance SHALL have no effect.
REQ-020 SHALL send the registered bytes in the order status, note, velocity, each byte MSB-first.
REQ-021 SHALL use SPI mode 0: spi_sclk idles low, spi_mosi changes on the falling edge, and the slave samples on the rising edge.
REQ-022 SHALL perform the following per byte:
- SETUP: drive nss low and present bit 7 on mosi, then hold for CLK_DIV cycles.
- 8 repetitions of SHIFT_HI (sclk high, CLK_DIV cycles) followed by SHIFT_LO (sclk low, CLK_DIV cycles).
- Shift in the next bit at the SHIFT_HI to SHIFT_LO transition.
REQ-023 SHALL raise nss after the 8th SHIFT_LO of each byte, then hold nss high in GAP for GAP_CYCLES cycles before the next byte's SETUP, so that the slave sees one nss frame per byte.
REQ-024 SHALL have the last byte go to DONE (nss high, one cycle) and then to IDLE.
REQ-025 SHALL take exactly 3*(17*CLK_DIV + GAP_CYCLES) + 1 cycles per full message from acceptance to msg_ready high again, with the gap counted after every byte.
REQ-026 SHALL have the internal SHIFT_HI sample of spi_miso, at the rising sclk edge, assemble an echo byte; a mismatch between the echo of byte N and transmitted byte N-1 SHALL be ignored, as it is informational only and exposes no port.
REQ-027 SHALL hold spi_sclk low and spi_mosi at 0 while nss is high.
REQ-028 SHALL use bit counters and divider counters that do not wrap mid-byte; the divider SHALL reload to CLK_DIV-1 at each phase change.

Reset
REQ-029 SHALL, on reset high at any time including mid-byte, immediately force spi_nss=1, spi_sclk=0, spi_mosi=0, msg_ready=0, msg_reject=0, busy=0 and the state to IDLE; the partial message SHALL be discarded.
REQ-030 SHALL drive msg_ready high on the first clk edge after reset deasserts.

Configuration
REQ-031 SHALL, when macro MIDI_RUNNING_STATUS_EN is defined, omit the status byte when it equals the last transmitted status; in that case only note and velocity are sent and the latency is 2*(17*CLK_DIV+GAP_CYCLES)+1.
REQ-032 SHALL clear the stored last status on reset and on any rejected message when MIDI_RUNNING_STATUS_EN is defined.
REQ-033 SHALL, when MIDI_RUNNING_STATUS_EN is undefined, always send all three bytes and store no last-status register.

Verification
REQ-034 SHALL verify this scenario: CLK_DIV=4, GAP=8, send {90,3C,7F} -> three nss frames carrying bytes 0x90, 0x3C, 0x7F; msg_ready returns after 229 cycles.
REQ-035 SHALL verify this scenario: msg_status=0xB0 -> msg_reject pulses one cycle, nss stays high, msg_ready stays high.
REQ-036 SHALL verify this scenario: reset asserted during bit 3 of the note byte -> nss=1 and sclk=0 within the same cycle, and a subsequent {80,3C,00} is sent cleanly.
REQ-037 SHALL verify this scenario: msg_valid held high with two messages back-to-back -> the second is accepted only after DONE, with no overlap of nss frames.
REQ-038 SHALL verify this scenario: with MIDI_RUNNING_STATUS_EN, {90,3C,7F} then {90,40,60} -> the second message sends only 0x40 and 0x60; then {80,40,00} -> all three bytes are sent.
REQ-039 SHALL verify this scenario: the mosi value is stable across every sclk rising edge in all of the above scenarios.
